// File: rtl/dual_down_counter.sv
// rtl/dual_down_counter.sv - two-channel 64-bit loadable down-counter with sticky zero flags
module dual_down_counter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Slt,
  input  logic        En,
  input  logic        Load,
  input  logic [63:0] LoadData,
  output logic [63:0] Output0,
  output logic [63:0] Output1,
  output logic        Zero0,
  output logic        Zero1
);

  logic [63:0] out0_q, out0_d;
  logic [63:0] out1_q, out1_d;
  logic        zero0_q, zero0_d;
  logic        zero1_q, zero1_d;
  logic [1:0]  pre_q, pre_d;

  always_comb begin
    out0_d  = out0_q;
    out1_d  = out1_q;
    zero0_d = zero0_q;
    zero1_d = zero1_q;
    pre_d   = pre_q;
    if (Load) begin
      if (!Slt) begin
        out0_d  = LoadData;
        zero0_d = 1'b0;
      end else begin
        out1_d  = LoadData;
        zero1_d = 1'b0;
        pre_d   = 2'd0;
      end
    end else if (En) begin
      if (!Slt) begin
        if (out0_q != 64'd0) begin
          out0_d = out0_q - 64'd1;
          if (out0_q == 64'd1) zero0_d = 1'b1;
        end
      end else if (out1_q != 64'd0) begin
        // A stopped channel 1 freezes its prescaler too, so a reload always starts a clean phase.
        pre_d = pre_q + 2'd1;
        if (pre_q == 2'd3) begin
          out1_d = out1_q - 64'd1;
          if (out1_q == 64'd1) zero1_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out0_q  <= 64'd0;
      out1_q  <= 64'd0;
      zero0_q <= 1'b0;
      zero1_q <= 1'b0;
      pre_q   <= 2'd0;
    end else begin
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      zero0_q <= zero0_d;
      zero1_q <= zero1_d;
      pre_q   <= pre_d;
    end
  end

  assign Output0 = out0_q;
  assign Output1 = out1_q;
  assign Zero0   = zero0_q;
  assign Zero1   = zero1_q;

endmodule

// File: tb/tb_dual_down_counter.sv
// tb/tb_dual_down_counter.sv - vector table and scoreboard bench for dual_down_counter
module tb_dual_down_counter;

  logic        clk = 1'b0;
  logic        rst, slt, en, ld;
  logic [63:0] data;
  logic [63:0] out0, out1;
  logic        z0, z1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst, slt, en, ld;
    logic [63:0] data;
    logic [63:0] e0, e1;
    logic        ez0, ez1;
  } vec_t;

  typedef struct {
    logic [63:0] e0, e1;
    logic        ez0, ez1;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  dual_down_counter dut (
    .Clk(clk), .Reset(rst), .Slt(slt), .En(en), .Load(ld), .LoadData(data),
    .Output0(out0), .Output1(out1), .Zero0(z0), .Zero1(z1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic r, s, e, l, input logic [63:0] d,
                              input logic [63:0] e0, e1, input logic ez0, ez1);
    vec_t v;
    v.rst = r; v.slt = s; v.en = e; v.ld = l; v.data = d;
    v.e0 = e0; v.e1 = e1; v.ez0 = ez0; v.ez1 = ez1;
    vecs.push_back(v);
  endfunction

  task automatic check64(input string name, input int idx, input logic [63:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input int idx, input logic r, s, e, l, input logic [63:0] d,
                      input logic [63:0] e0, e1, input logic ez0, ez1);
    exp_t x;
    x.e0 = e0; x.e1 = e1; x.ez0 = ez0; x.ez1 = ez1;
    rst = r; slt = s; en = e; ld = l; data = d;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check64("Output0", idx, out0, x.e0);
    check64("Output1", idx, out1, x.e1);
    check64("Zero0", idx, {63'd0, z0}, {63'd0, x.ez0});
    check64("Zero1", idx, {63'd0, z1}, {63'd0, x.ez1});
  endtask

  initial begin
    rst = 1'b1; slt = 1'b0; en = 1'b0; ld = 1'b0; data = 64'd0;

    // reset beats a simultaneous load
    add(1,0,0,1,5, 0,0,0,0);
    add(1,0,0,1,5, 0,0,0,0);
    // channel 0 countdown from 3, holds at 0 with sticky flag
    add(0,0,0,1,3, 3,0,0,0);
    add(0,0,1,0,0, 2,0,0,0);
    add(0,0,1,0,0, 1,0,0,0);
    add(0,0,1,0,0, 0,0,1,0);
    add(0,0,1,0,0, 0,0,1,0);
    add(0,0,1,0,0, 0,0,1,0);
    // channel 1 prescale from 2
    add(0,1,0,1,2, 0,2,1,0);
    for (int i = 1; i <= 9; i++)
      add(0,1,1,0,0, 0, (i < 4) ? 64'd2 : (i < 8) ? 64'd1 : 64'd0, 1, (i >= 8));
    // prescaler retention across Slt=0 and En=0
    add(0,1,0,1,5, 0,5,1,0);
    add(0,1,1,0,0, 0,5,1,0);
    add(0,1,1,0,0, 0,5,1,0);
    for (int i = 0; i < 3; i++) add(0,0,1,0,0, 0,5,1,0);
    for (int i = 0; i < 2; i++) add(0,1,0,0,0, 0,5,1,0);
    add(0,1,1,0,0, 0,5,1,0);
    add(0,1,1,0,0, 0,4,1,0);
    // load precedence over En, then zero load never sets the flag
    add(0,0,0,1,1, 1,4,0,0);
    add(0,0,1,1,7, 7,4,0,0);
    add(0,0,0,1,0, 0,4,0,0);
    add(0,0,1,0,0, 0,4,0,0);
    add(0,0,1,0,0, 0,4,0,0);

    for (int i = 0; i < vecs.size(); i++)
      step(i, vecs[i].rst, vecs[i].slt, vecs[i].en, vecs[i].ld, vecs[i].data,
           vecs[i].e0, vecs[i].e1, vecs[i].ez0, vecs[i].ez1);

    // sticky Zero0 survives channel 1 counting, cleared by reload
    step(100, 0,0,0,1,1, 1,4,0,0);
    step(101, 0,0,1,0,0, 0,4,1,0);
    for (int i = 1; i <= 10; i++)
      step(101 + i, 0,1,1,0,0, 0, (i < 4) ? 64'd4 : (i < 8) ? 64'd3 : 64'd2, 1, 0);
    step(112, 0,0,0,1,4, 4,2,0,0);

    // load wins on the edge a count would reach 0
    step(120, 0,0,0,1,1, 1,2,0,0);
    step(121, 0,0,1,1,9, 9,2,0,0);

    // full-width borrow
    step(130, 0,0,0,1,64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,2,0,0);
    step(131, 0,0,1,0,0, 64'h7FFF_FFFF_FFFF_FFFF,2,0,0);

    // reset mid-count overrides En
    step(140, 1,1,1,0,0, 0,0,0,0);
    step(141, 0,1,1,0,0, 0,0,0,0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
